// File: rtl/mfu_digit_serial_mul.sv
// Digit-serial multiplier sequencer: splits 2/4/8-bit operands into 2-bit digits and
// shift-accumulates one signed/unsigned 2b x 2b digit product per cycle into a PW-bit product.
module mfu_digit_serial_mul #(
  parameter int unsigned DW = 8,
  parameter int unsigned PW = 2 * DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          a_signed,
  input  logic          b_signed,
  input  logic [1:0]    prec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  output logic          busy
);

  localparam int unsigned ND = DW / 2;
  localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned SW = IW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   a_r, b_r;
  logic            as_r, bs_r;
  logic [IW-1:0]   last_r, last_nx;
  logic [IW-1:0]   i, j;
  logic [PW-1:0]   acc, acc_nx, p_r, term;
  logic [1:0]      ad, bd;
  logic signed [2:0] da, db;
  logic signed [5:0] pp;
  logic [SW-1:0]   sh;
  logic            accept, last_pair;
  int unsigned     ndig;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = p_r;
  assign accept    = in_valid && in_ready;
  assign last_pair = (i == last_r) && (j == last_r);

  // Digit count per precision, clamped to what DW can hold; stored as N-1.
  always_comb begin
    ndig = 4;
    unique case (prec)
      2'd0:    ndig = 1;
      2'd1:    ndig = 2;
      default: ndig = 4;
    endcase
    if (ndig > ND) ndig = ND;
    last_nx = IW'(ndig - 1);
  end

  // Only the top digit of a signed operand carries a sign; lower digits are unsigned.
  always_comb begin
    ad     = a_r[{i, 1'b0} +: 2];
    bd     = b_r[{j, 1'b0} +: 2];
    da     = signed'({as_r && (i == last_r) && ad[1], ad});
    db     = signed'({bs_r && (j == last_r) && bd[1], bd});
    pp     = da * db;
    sh     = {({1'b0, i} + {1'b0, j}), 1'b0};
    term   = {{(PW-6){pp[5]}}, pp} << sh;
    acc_nx = acc + term;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_pair) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      as_r   <= 1'b0;
      bs_r   <= 1'b0;
      last_r <= '0;
      i      <= '0;
      j      <= '0;
      acc    <= '0;
      p_r    <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_r    <= a;
          b_r    <= b;
          as_r   <= a_signed;
          bs_r   <= b_signed;
          last_r <= last_nx;
          i      <= '0;
          j      <= '0;
          acc    <= '0;
        end
        RUN: begin
          acc <= acc_nx;
          if (last_pair) begin
            p_r <= acc_nx;
          end else if (j == last_r) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mfu_digit_serial_mul.sv
// Scoreboard bench for mfu_digit_serial_mul: driver pushes expected product and latency,
// an independent monitor compares whenever the DUT presents out_valid.
module tb_mfu_digit_serial_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic [1:0]  prec = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] p;
  logic        busy;

  always #5 clk = ~clk;

  mfu_digit_serial_mul #(.DW(8), .PW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .prec(prec),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  typedef struct {
    logic [15:0] p;
    int          lat;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lat_of(input logic [1:0] pr);
    return (pr == 2'd0) ? 1 : (pr == 2'd1) ? 4 : 16;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic xs, input logic ys, input logic [1:0] pr);
    int     w;
    longint xv, yv;
    w  = (pr == 2'd0) ? 2 : (pr == 2'd1) ? 4 : 8;
    xv = longint'(x) & ((longint'(1) << w) - 1);
    yv = longint'(y) & ((longint'(1) << w) - 1);
    if (xs && (((xv >> (w - 1)) & 1) == 1)) xv = xv - (longint'(1) << w);
    if (ys && (((yv >> (w - 1)) & 1) == 1)) yv = yv - (longint'(1) << w);
    return 16'(xv * yv);
  endfunction

  // Monitor: compare on first sight of out_valid, then require p to hold until taken.
  initial begin : monitor
    bit          seen;
    logic [15:0] held;
    exp_t        e;
    seen = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb[0];
          if (!seen) begin
            check("p", {16'b0, p}, {16'b0, e.p});
            check("latency", cyc - e.edge_no, e.lat);
            held = p;
            seen = 1;
          end else begin
            check("p_hold", {16'b0, p}, {16'b0, held});
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ias,
                       input logic ibs, input logic [1:0] ip, input logic [15:0] ep,
                       input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    a = ia; b = ib; a_signed = ias; b_signed = ibs; prec = ip; in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    if (push) sb.push_back('{p: ep, lat: lat_of(ip), edge_no: cyc + 1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ia; b = ~ib; a_signed = ~ias; b_signed = ~ibs; prec = ~ip;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin : watchdog
    #(10 * 40000);
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : driver
    logic [7:0] corn [6];
    logic [7:0] va, vb;
    int guard;
    corn = '{8'h00, 8'hFF, 8'h02, 8'h08, 8'h80, 8'h7F};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_p", {16'b0, p}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors
    issue(8'h03, 8'h03, 1'b0, 1'b0, 2'd0, 16'h0009, 1);
    drain();
    issue(8'h80, 8'h80, 1'b1, 1'b1, 2'd2, 16'h4000, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("busy_run", {31'b0, busy}, 32'd1);
    end
    drain();
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 2'd2, 16'hFF01, 1);
    issue(8'hF8, 8'h07, 1'b1, 1'b1, 2'd1, 16'hFFC8, 1);
    drain();

    // Backpressure: product 2*4 at w=4, held in DONE with in_valid asserted
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b0, 2'd1, 16'h0008, 1);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset during the 5th RUN cycle discards the op
    issue(8'h55, 8'h55, 1'b0, 1'b0, 2'd2, 16'h0000, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_in_rst", {31'b0, in_ready}, 32'd0);
    check("abort_busy_before_edge", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_p_cleared", {16'b0, p}, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_output", {31'b0, out_valid}, 32'd0);
    issue(8'h7F, 8'h81, 1'b1, 1'b1, 2'd2, 16'hC0FF, 1);
    drain();

    // Sweep precision x signedness with corner and random operands
    for (int pr = 0; pr < 4; pr++) begin
      for (int sg = 0; sg < 4; sg++) begin
        for (int k = 0; k < 24; k++) begin
          if (k < 6) begin
            va = corn[k];
            vb = corn[5 - k];
          end else begin
            va = 8'($urandom);
            vb = 8'($urandom);
          end
          issue(va, vb, sg[1], sg[0], 2'(pr),
                model(va, vb, sg[1], sg[0], 2'(pr)), 1);
        end
      end
      drain();
    end

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
